// File: rtl/bram2_be_init.sv
// True-dual-port RAM with byte enables, selectable same-port read mode, A-wins collision merge,
// read-valid tracking through an optional output register, and a post-reset clear sweep.
module bram2_be_init_out #(
  parameter int DW        = 1,
  parameter int PIPELINED = 0
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          acc,
  input  logic [DW-1:0] rd,
  output logic [DW-1:0] dout,
  output logic          valid
);
  logic [DW-1:0] d1;
  logic          v1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      d1 <= '0;
      v1 <= 1'b0;
    end else begin
      v1 <= acc;
      if (acc) d1 <= rd;
    end
  end

  generate
    if (PIPELINED != 0) begin : g_pipe
      logic [DW-1:0] d2;
      logic          v2;
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          d2 <= '0;
          v2 <= 1'b0;
        end else begin
          d2 <= d1;
          v2 <= v1;
        end
      end
      assign dout  = d2;
      assign valid = v2;
    end else begin : g_direct
      assign dout  = d1;
      assign valid = v1;
    end
  endgenerate
endmodule

module bram2_be_init #(
  parameter int PIPELINED      = 0,
  parameter int ADDR_WIDTH     = 1,
  parameter int DATA_WIDTH     = 1,
  parameter int MEMSIZE        = 1,
  parameter int BYTE_WIDTH     = 8,
  parameter int WRITE_MODE     = 0,
  parameter int CLEAR_ON_RESET = 1,
  parameter logic [DATA_WIDTH-1:0] INIT_VALUE = '0,
  localparam int NBYTES = (DATA_WIDTH + BYTE_WIDTH - 1) / BYTE_WIDTH
) (
  input  logic                  CLK,
  input  logic                  RST_N,
  input  logic                  ENA,
  input  logic [NBYTES-1:0]     WEA,
  input  logic [ADDR_WIDTH-1:0] ADDRA,
  input  logic [DATA_WIDTH-1:0] DIA,
  output logic [DATA_WIDTH-1:0] DOA,
  output logic                  DOA_VALID,
  input  logic                  ENB,
  input  logic [NBYTES-1:0]     WEB,
  input  logic [ADDR_WIDTH-1:0] ADDRB,
  input  logic [DATA_WIDTH-1:0] DIB,
  output logic [DATA_WIDTH-1:0] DOB,
  output logic                  DOB_VALID,
  output logic                  INIT_DONE
);
  localparam int              IW   = (MEMSIZE > 1) ? $clog2(MEMSIZE) : 1;
  localparam logic [31:0]     MSZ  = MEMSIZE;
  localparam logic [IW-1:0]   LAST = IW'(MEMSIZE - 1);

  typedef enum logic {CLEAR, READY} state_t;

  state_t                state;
  logic [IW-1:0]         cnt;
  logic [DATA_WIDTH-1:0] mem [MEMSIZE];

  logic [DATA_WIDTH-1:0] mask_a, mask_b, old_a, old_b, mrg_a, mrg_b, rd_a, rd_b;
  logic                  in_a, in_b, acc_a, acc_b, wr_a, wr_b, same;
  logic [IW-1:0]         ia, ib;

  // Expand lane enables to a per-bit mask; the top lane may be narrower than BYTE_WIDTH.
  for (genvar i = 0; i < DATA_WIDTH; i++) begin : g_mask
    assign mask_a[i] = WEA[i / BYTE_WIDTH];
    assign mask_b[i] = WEB[i / BYTE_WIDTH];
  end

  assign in_a  = 32'(ADDRA) < MSZ;
  assign in_b  = 32'(ADDRB) < MSZ;
  assign ia    = IW'(ADDRA);
  assign ib    = IW'(ADDRB);
  assign acc_a = (state == READY) && ENA;
  assign acc_b = (state == READY) && ENB;
  assign wr_a  = acc_a && (|WEA) && in_a;
  assign wr_b  = acc_b && (|WEB) && in_b;
  assign same  = (ADDRA == ADDRB);
  assign old_a = in_a ? mem[ia] : '0;
  assign old_b = in_b ? mem[ib] : '0;

  // On a shared address A's merge is layered over B's, so A wins on lanes both enable.
  assign mrg_b = (old_b & ~mask_b) | (DIB & mask_b);
  assign mrg_a = (same && wr_b) ? ((mrg_b & ~mask_a) | (DIA & mask_a))
                                : ((old_a & ~mask_a) | (DIA & mask_a));

  always_comb begin
    rd_a = '0;
    rd_b = '0;
    if (in_a) rd_a = (WRITE_MODE != 0 && wr_a) ? mrg_a : old_a;
    if (in_b) rd_b = (WRITE_MODE != 0 && wr_b) ? ((same && wr_a) ? mrg_a : mrg_b) : old_b;
  end

  // Later non-blocking write of A overrides B on a same-address collision.
  always_ff @(posedge CLK) begin
    if (state == CLEAR) begin
      mem[cnt] <= INIT_VALUE;
    end else begin
      if (wr_b) mem[ib] <= mrg_b;
      if (wr_a) mem[ia] <= mrg_a;
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state     <= (CLEAR_ON_RESET != 0) ? CLEAR : READY;
      cnt       <= '0;
      INIT_DONE <= 1'b0;
    end else begin
      case (state)
        CLEAR: begin
          cnt <= cnt + 1'b1;
          if (cnt == LAST) begin
            state     <= READY;
            INIT_DONE <= 1'b1;
          end
        end
        default: INIT_DONE <= 1'b1;
      endcase
    end
  end

  bram2_be_init_out #(.DW(DATA_WIDTH), .PIPELINED(PIPELINED)) u_out_a (
    .clk(CLK), .rst_n(RST_N), .acc(acc_a), .rd(rd_a), .dout(DOA), .valid(DOA_VALID)
  );

  bram2_be_init_out #(.DW(DATA_WIDTH), .PIPELINED(PIPELINED)) u_out_b (
    .clk(CLK), .rst_n(RST_N), .acc(acc_b), .rd(rd_b), .dout(DOB), .valid(DOB_VALID)
  );
endmodule
